// File: rtl/io_serial_tx_pkg.sv
// Shared constants for the I/O-mapped serial transmitter: register offsets,
// STATUS bit positions and the transmit FSM encoding.
package io_serial_tx_pkg;

  localparam int unsigned IO_TX_DATA_OFS = 0;
  localparam int unsigned IO_TX_STAT_OFS = 1;

  localparam int unsigned IO_TX_ST_FULL    = 0;
  localparam int unsigned IO_TX_ST_EMPTY   = 1;
  localparam int unsigned IO_TX_ST_ACTIVE  = 2;
  localparam int unsigned IO_TX_ST_OVF     = 3;
  localparam int unsigned IO_TX_ST_CNT_LSB = 4;
  localparam int unsigned IO_TX_ST_CNT_MSB = 7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [15:0] io_tx_reg_addr(input logic [15:0] base,
                                                 input int unsigned ofs);
    return base + 16'(ofs);
  endfunction

endpackage

// File: rtl/io_serial_tx_if.sv
// CPU I/O port bus as seen by a device: CPU drives address/strobes/write data,
// device returns read data.
interface io_serial_tx_if;
  logic [15:0] io_access_addr;
  logic [15:0] io_in;
  logic        io_write_en;
  logic        io_read_en;
  logic [15:0] io_out;

  modport master (
    output io_access_addr,
    output io_in,
    output io_write_en,
    output io_read_en,
    input  io_out
  );

  modport slave (
    input  io_access_addr,
    input  io_in,
    input  io_write_en,
    input  io_read_en,
    output io_out
  );
endinterface

// File: rtl/io_serial_tx_fifo.sv
// Small byte FIFO with wrap-bit pointers; head word is presented combinationally
// so the consumer can load it on the same edge it pops.
module io_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap modulo 2*DEPTH; the extra bit separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_serial_tx.sv
// I/O-mapped 8N1 transmitter: CPU writes bytes to DATA, reads STATUS; bytes
// are queued and shifted out LSB first on tx_serial.
module io_serial_tx
  import io_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [15:0] BASE_ADDR    = 16'h8000
) (
  input  logic         clk,
  input  logic         rst,
  io_serial_tx_if.slave bus,
  output logic         tx_serial,
  output logic         tx_busy
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [15:0] DATA_ADDR = io_tx_reg_addr(BASE_ADDR, IO_TX_DATA_OFS);
  localparam logic [15:0] STAT_ADDR = io_tx_reg_addr(BASE_ADDR, IO_TX_STAT_OFS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              overflow;

  logic              wr_hit_c;
  logic              stat_rd_c;
  logic              push_c;
  logic              pop_c;
  logic              baud_end_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [7:0]        fifo_rdata;
  logic              unused_hi;

  assign unused_hi  = ^bus.io_in[15:8];

  assign wr_hit_c   = bus.io_write_en && (bus.io_access_addr == DATA_ADDR);
  assign stat_rd_c  = bus.io_read_en && (bus.io_access_addr == STAT_ADDR);
  assign push_c     = wr_hit_c && !fifo_full;
  assign baud_end_c = (baud_cnt == BAUD_LAST);
  // A new byte is taken either from idle or back-to-back at the end of a stop bit.
  assign pop_c      = !fifo_empty &&
                      ((state == TX_IDLE) || ((state == TX_STOP) && baud_end_c));

  io_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata (bus.io_in[7:0]),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow; a same-cycle drop wins over the STATUS-read clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_hit_c && fifo_full) begin
      overflow <= 1'b1;
    end else if (stat_rd_c) begin
      overflow <= 1'b0;
    end
  end

  // Frame sequencer; tx_serial is loaded with the level of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TX_IDLE;
      tx_serial <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          tx_serial <= 1'b1;
          baud_cnt  <= '0;
          if (pop_c) begin
            shift     <= fifo_rdata;
            state     <= TX_START;
            tx_serial <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_end_c) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            state     <= TX_DATA;
            tx_serial <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        TX_DATA: begin
          if (baud_end_c) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state     <= TX_STOP;
              tx_serial <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        TX_STOP: begin
          if (baud_end_c) begin
            baud_cnt <= '0;
            if (pop_c) begin
              shift     <= fifo_rdata;
              state     <= TX_START;
              tx_serial <= 1'b0;
            end else begin
              state     <= TX_IDLE;
              tx_serial <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state     <= TX_IDLE;
          tx_serial <= 1'b1;
        end
      endcase
    end
  end

  assign tx_busy = !fifo_empty || (state != TX_IDLE);

  // STATUS is the only readable register; everything else reads as zero.
  always_comb begin
    bus.io_out = '0;
    if (stat_rd_c) begin
      bus.io_out[IO_TX_ST_FULL]   = fifo_full;
      bus.io_out[IO_TX_ST_EMPTY]  = fifo_empty;
      bus.io_out[IO_TX_ST_ACTIVE] = (state != TX_IDLE);
      bus.io_out[IO_TX_ST_OVF]    = overflow;
      bus.io_out[IO_TX_ST_CNT_MSB:IO_TX_ST_CNT_LSB] = 4'(fifo_count);
    end
  end

endmodule

// File: tb/tb_io_serial_tx.sv
// Bench for io_serial_tx: directed CPU bus traffic, a serial-line monitor that
// decodes frames and checks them against a queue of expected bytes.
module tb_io_serial_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic clk;
  logic rst;
  logic tx_serial;
  logic tx_busy;

  io_serial_tx_if bus ();

  io_serial_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (16'h8000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic mon_busy = 1'b0;
  int frames_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 16'h%h, expected 16'h%h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves the strobe up across exactly one posedge.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    bus.io_access_addr = a;
    bus.io_in          = d;
    bus.io_write_en    = 1'b1;
    @(negedge clk);
    bus.io_write_en    = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [15:0] exp, input string name);
    bus.io_access_addr = a;
    bus.io_read_en     = 1'b1;
    #1;
    chk(name, bus.io_out, exp);
    @(negedge clk);
    bus.io_read_en     = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while ((tx_busy || mon_busy || exp_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(name, 16'(n < max_cyc), 16'd1);
  endtask

  // Line monitor: every bit must hold for CPB samples; aborted frames are discarded.
  initial begin : monitor
    logic [FRAME-1:0] samp;
    logic [7:0] got;
    logic aborted;
    int shape_err;
    @(negedge clk);
    while (rst) @(negedge clk);
    forever begin
      @(negedge clk);
      if (!rst && tx_serial == 1'b0) begin
        mon_busy = 1'b1;
        aborted  = 1'b0;
        samp     = '0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          samp[i] = tx_serial;
        end
        if (aborted) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          frames_seen++;
          shape_err = 0;
          for (int i = 0; i < FRAME; i++)
            if (samp[i] !== samp[(i / CPB) * CPB]) shape_err++;
          for (int b = 0; b < 8; b++) got[b] = samp[(b + 1) * CPB];
          chk("frame_shape", 16'(shape_err), 16'd0);
          chk("frame_stop", 16'(samp[9 * CPB]), 16'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte 8'h%h, expected no frame", got);
          end else begin
            chk("frame_data", {8'h00, got}, {8'h00, exp_q.pop_front()});
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cnt;
    int lows;
    bus.io_access_addr = 16'h0000;
    bus.io_in          = 16'h0000;
    bus.io_write_en    = 1'b0;
    bus.io_read_en     = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("reset_line", 16'(tx_serial), 16'd1);
    chk("reset_busy", 16'(tx_busy), 16'd0);
    bus_read(16'h8001, 16'h0002, "reset_status");

    // Decode: non-DATA writes ignored, DATA reads zero, no read strobe -> zero
    bus_write(16'h8002, 16'h0077);
    bus_write(16'h0000, 16'h0012);
    bus_write(16'h8001, 16'h0033);
    @(negedge clk);
    chk("decode_busy", 16'(tx_busy), 16'd0);
    bus_read(16'h8001, 16'h0002, "decode_status");
    bus_read(16'h8000, 16'h0000, "data_read");
    bus.io_access_addr = 16'h8001;
    #1 chk("no_read_en", bus.io_out, 16'h0000);
    @(negedge clk);

    // Single frame 0xA5: latency and length
    exp_q.push_back(8'hA5);
    bus_write(16'h8000, 16'h00A5);
    chk("lat_pre_line", 16'(tx_serial), 16'd1);
    chk("lat_pre_busy", 16'(tx_busy), 16'd1);
    @(negedge clk);
    chk("lat_start", 16'(tx_serial), 16'd0);
    cnt = 0;
    while (tx_busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_len_1", 16'(cnt), 16'(FRAME));
    wait_idle(100, "idle_a5");

    // Back-to-back: upper byte ignored, zero gap between frames
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h81);
    bus_write(16'h8000, 16'hFF3C);
    bus_write(16'h8000, 16'h0081);
    cnt = 0;
    while (tx_busy && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_len_2", 16'(cnt), 16'(2 * FRAME));
    wait_idle(100, "idle_b2b");

    // Overflow: six consecutive writes, sixth dropped
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    bus_write(16'h8000, 16'h0011);
    bus_write(16'h8000, 16'h0022);
    bus_write(16'h8000, 16'h0033);
    bus_write(16'h8000, 16'h0044);
    bus_write(16'h8000, 16'h0055);
    bus_write(16'h8000, 16'h0066);
    bus_read(16'h8001, 16'h004D, "ovf_status");
    bus_read(16'h8001, 16'h0045, "ovf_cleared");
    wait_idle(6 * FRAME, "idle_ovf");

    // Reset mid-DATA of a 0x00 frame
    exp_q.push_back(8'h00);
    bus_write(16'h8000, 16'h0000);
    repeat (12) @(negedge clk);
    chk("pre_rst_line", 16'(tx_serial), 16'd0);
    #1 rst = 1'b1;
    #1;
    chk("rst_line", 16'(tx_serial), 16'd1);
    chk("rst_busy", 16'(tx_busy), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_read(16'h8001, 16'h0002, "post_rst_status");
    lows = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    chk("post_rst_quiet", 16'(lows), 16'd0);

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    chk("frames_seen", 16'(frames_seen), 16'd8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
